inst_encoder: RTL and testbench

- Inverse of the instruction decoder. Accepts decoded RV32I fields (op, funct3, funct7, rs1, rs2, rd, imm) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word and checks that the immediate is legal for the format.
- Buffers results in a small output FIFO.
- Used by the test-program generator and the self-check loopback path: encoder output feeds the decoder, and the decoder's fields are compared with the encoder's inputs.

---
 rtl/inst_encoder.sv | 199 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I field-to-instruction encoder: packs decoded fields back into a 32-bit
// word, flags illegal opcodes/immediates, and queues results in an output FIFO.
module inst_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic              out_err,
    output logic [CNT_W-1:0]  enc_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam int unsigned INST_W = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    fmt_e              fmt;
    logic              fits_12;
    logic              fits_13;
    logic              fits_21;
    logic              sh_f7_ok;
    logic [INST_W-1:0] enc_word;
    logic              enc_err;

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic              mem_err  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] count;

    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_n;
    logic [CNT_FW-1:0] count_n;
    logic [INST_W-1:0] head_inst_n;
    logic              head_err_n;

    // Instruction format selected by opcode; shift-immediates are an I sub-form.
    always_comb begin
        fmt = FMT_BAD;
        case (op)
            OP_R:                                         fmt = FMT_R;
            OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:        fmt = FMT_I;
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) fmt = FMT_SH;
                else                                      fmt = FMT_I;
            end
            OP_STORE:                                     fmt = FMT_S;
            OP_BRANCH:                                    fmt = FMT_B;
            OP_LUI, OP_AUIPC:                             fmt = FMT_U;
            OP_JAL:                                       fmt = FMT_J;
            default:                                      fmt = FMT_BAD;
        endcase
    end

    // Signed range checks: upper bits must all equal the field's sign bit.
    always_comb begin
        fits_12  = (&imm[31:11]) || !(|imm[31:11]);
        fits_13  = (&imm[31:12]) || !(|imm[31:12]);
        fits_21  = (&imm[31:20]) || !(|imm[31:20]);
        sh_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    end

    // Field packing; illegal bundles are still packed from truncated fields.
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, op};
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, op};
                enc_err  = !fits_12;
            end
            FMT_SH: begin
                enc_word = {funct7, imm[4:0], rs1, funct3, rd, op};
                enc_err  = (|imm[31:5]) || !sh_f7_ok;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                enc_err  = !fits_12;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                enc_err  = !fits_13 || imm[0];
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, op};
                enc_err  = |imm[11:0];
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                enc_err  = !fits_21 || imm[0];
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // FIFO next state, including the head value the registered outputs will show.
    always_comb begin
        wr_ptr_n    = wr_ptr + PTR_W'(push);
        rd_ptr_n    = rd_ptr + PTR_W'(pop);
        count_n     = count + CNT_FW'(push) - CNT_FW'(pop);
        head_inst_n = '0;
        head_err_n  = 1'b0;
        if (count_n != '0) begin
            if (count == CNT_FW'(pop)) begin
                // FIFO is empty after any pop, so the new bundle becomes head.
                head_inst_n = enc_word;
                head_err_n  = enc_err;
            end else begin
                head_inst_n = mem_inst[rd_ptr_n];
                head_err_n  = mem_err[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_inst[wr_ptr] <= enc_word;
            mem_err[wr_ptr]  <= enc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            in_ready  <= (count_n != CNT_FW'(DEPTH));
            out_valid <= (count_n != '0);
            out_inst  <= head_inst_n;
            out_err   <= head_err_n;
            if (push) begin
                enc_count <= enc_count + CNT_W'(1);
                if (enc_err) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: a queue-based reference model plus a
// decode-back loopback check of every legal word.
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic              out_err;
    logic [CNT_W-1:0]  enc_count;
    logic [CNT_W-1:0]  err_count;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        err;
        logic [63:0] fields;
    } ent_t;

    ent_t             q[$];
    logic [CNT_W-1:0] m_enc;
    logic [CNT_W-1:0] m_err;
    int               n_acc;
    int               n_checks;
    int               n_errors;
    logic [6:0]       i_ops [5] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0=R 1=I 2=shift-imm 3=S 4=B 5=U 6=J 7=unknown opcode
    function automatic int fmt_of(input logic [6:0] o, input logic [2:0] f3);
        case (o)
            7'b0110011: return 0;
            7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
            7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: return 1;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b0110111, 7'b0010111: return 5;
            7'b1101111: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                         input logic [31:0] im);
        return {o, f3, f7, r1, r2, d, im};
    endfunction

    // Fields a decoder can recover from a legal word; absent fields read as zero.
    function automatic logic [63:0] norm_in(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                            input logic [31:0] im);
        case (fmt_of(o, f3))
            0: return pack(o, f3, f7, r1, r2, d, 32'd0);
            1: return pack(o, f3, 7'd0, r1, 5'd0, d, im);
            2: return pack(o, f3, f7, r1, 5'd0, d, im);
            3, 4: return pack(o, f3, 7'd0, r1, r2, 5'd0, im);
            5, 6: return pack(o, 3'd0, 7'd0, 5'd0, 5'd0, d, im);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] decode(input logic [31:0] w);
        logic [31:0] im;
        im = 32'd0;
        case (fmt_of(w[6:0], w[14:12]))
            0: return pack(w[6:0], w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], 32'd0);
            1: begin
                im = {{20{w[31]}}, w[31:20]};
                return pack(w[6:0], w[14:12], 7'd0, w[19:15], 5'd0, w[11:7], im);
            end
            2: return pack(w[6:0], w[14:12], w[31:25], w[19:15], 5'd0, w[11:7], {27'd0, w[24:20]});
            3: begin
                im = {{20{w[31]}}, w[31:25], w[11:7]};
                return pack(w[6:0], w[14:12], 7'd0, w[19:15], w[24:20], 5'd0, im);
            end
            4: begin
                im = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                return pack(w[6:0], w[14:12], 7'd0, w[19:15], w[24:20], 5'd0, im);
            end
            5: return pack(w[6:0], 3'd0, 7'd0, 5'd0, 5'd0, w[11:7], {w[31:12], 12'd0});
            6: begin
                im = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                return pack(w[6:0], 3'd0, 7'd0, 5'd0, 5'd0, w[11:7], im);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference encoder: legality from integer ranges, word from the format tables.
    function automatic void model_encode(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                         input logic [31:0] im, output logic [31:0] w, output logic e);
        int s;
        s = int'($signed(im));
        w = 32'h0000_0013;
        e = 1'b1;
        case (fmt_of(o, f3))
            0: begin w = {f7, r2, r1, f3, d, o}; e = 1'b0; end
            1: begin w = {im[11:0], r1, f3, d, o}; e = !(s >= -2048 && s <= 2047); end
            2: begin
                w = {f7, im[4:0], r1, f3, d, o};
                e = !(s >= 0 && s <= 31) || !(f7 == 7'd0 || f7 == 7'd32);
            end
            3: begin w = {im[11:5], r2, r1, f3, im[4:0], o}; e = !(s >= -2048 && s <= 2047); end
            4: begin
                w = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], o};
                e = !(s >= -4096 && s <= 4094) || (s % 2 != 0);
            end
            5: begin w = {im[31:12], d, o}; e = (s % 4096 != 0); end
            6: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, o};
                e = !(s >= -1048576 && s <= 1048574) || (s % 2 != 0);
            end
            default: begin w = 32'h0000_0013; e = 1'b1; end
        endcase
    endfunction

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        if (q.size() != 0) begin
            check("out_inst", 64'(out_inst), 64'(q[0].word));
            check("out_err", 64'(out_err), 64'(q[0].err));
            if (!q[0].err) check("loopback", decode(out_inst), q[0].fields);
        end else begin
            check("out_inst_empty", 64'(out_inst), 64'd0);
            check("out_err_empty", 64'(out_err), 64'd0);
        end
        check("enc_count", 64'(enc_count), 64'(m_enc));
        check("err_count", 64'(err_count), 64'(m_err));
    endtask

    // One clock: predict from current inputs, advance, update model, compare.
    task automatic cycle();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        ent_t dropped;
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() != 0);
        model_encode(op, funct3, funct7, rs1, rs2, rd, imm, e.word, e.err);
        e.fields = norm_in(op, funct3, funct7, rs1, rs2, rd, imm);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_enc = '0;
            m_err = '0;
        end else begin
            if (do_pop) dropped = q.pop_front();
            if (do_push) begin
                q.push_back(e);
                m_enc = m_enc + 16'd1;
                if (e.err) m_err = m_err + 16'd1;
                n_acc++;
            end
        end
        check_outputs();
    endtask

    task automatic set_bundle(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                              input logic [31:0] im);
        op = o; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = d; imm = im;
    endtask

    task automatic push_one();
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic gen_bundle(input bit allow_err);
        int          k;
        logic [31:0] t;
        t      = $urandom;
        k      = $urandom_range(0, 10);
        rs1    = 5'($urandom);
        rs2    = 5'($urandom);
        rd     = 5'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        imm    = $urandom;
        case (k)
            0: op = 7'b0110011;
            1, 2, 3, 4, 5: begin
                op = i_ops[k-1];
                if (op == 7'b0010011 && (funct3 == 3'd1 || funct3 == 3'd5)) begin
                    imm    = 32'($urandom_range(0, 31));
                    funct7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                end else begin
                    imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                end
            end
            6: begin op = 7'b0100011; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
            7: begin op = 7'b1100011; imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
            8, 9: begin op = (k == 8) ? 7'b0110111 : 7'b0010111; imm = {t[31:12], 12'd0}; end
            default: begin op = 7'b1101111; imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1; end
        endcase
        if (allow_err && $urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
                0: op = ($urandom_range(0, 1) != 0) ? 7'b1111111 : 7'b1011011;
                1: imm = imm ^ 32'h0010_0800;
                default: imm = imm | 32'd1;
            endcase
        end
    endtask

    task automatic random_phase(input int target, input bit allow_err, input int budget);
        int start;
        start = n_acc;
        for (int c = 0; c < budget && (n_acc - start) < target; c++) begin
            if (!(in_valid && q.size() >= DEPTH)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) gen_bundle(allow_err);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        check("phase_accepted", 64'(n_acc - start), 64'(target));
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_acc = 0;
        m_enc = '0; m_err = '0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_bundle(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Directed format sweep, each drained before the next.
        set_bundle(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        push_one();
        check("addi_word", 64'(out_inst), 64'h0050_0093);
        check("addi_count", 64'(enc_count), 64'd1);
        cycle();
        set_bundle(7'b0100011, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        push_one(); check("sw_word", 64'(out_inst), 64'h0020_A423); cycle();
        set_bundle(7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, -32'sd4);
        push_one(); check("beq_word", 64'(out_inst), 64'hFE20_8EE3); cycle();
        set_bundle(7'b0110111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd3, 32'h1234_5000);
        push_one(); check("lui_word", 64'(out_inst), 64'h1234_51B7); cycle();
        set_bundle(7'b1101111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048);
        push_one(); check("jal_word", 64'(out_inst), 64'h0010_00EF); check("jal_err", 64'(out_err), 64'd0); cycle();

        // Error bundles.
        set_bundle(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd4096);
        push_one(); check("addi_big_err", 64'(out_err), 64'd1); cycle();
        set_bundle(7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        push_one(); check("beq_odd_err", 64'(out_err), 64'd1); cycle();
        set_bundle(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        push_one(); check("badop_word", 64'(out_inst), 64'h0000_0013); check("badop_err", 64'(out_err), 64'd1); cycle();
        set_bundle(7'b0010011, 3'b001, 7'd0, 5'd1, 5'd0, 5'd1, 32'd32);
        push_one(); check("slli_err", 64'(out_err), 64'd1); cycle();
        check("err_count_4", 64'(err_count), 64'd4);

        // Backpressure: fill, single pop, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin gen_bundle(1'b0); cycle(); end
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();

        // Half-full steady state: concurrent push and pop.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin gen_bundle(1'b0); cycle(); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin gen_bundle(1'b1); cycle(); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Reset with three entries queued and a bundle presented.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin gen_bundle(1'b0); cycle(); end
        gen_bundle(1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_enc_count", 64'(enc_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cycle();
        check("rst_dropped", 64'(out_valid), 64'd0);

        // Loopback of legal bundles, then a mixed stream with errors.
        random_phase(1000, 1'b0, 6000);
        random_phase(300, 1'b1, 2000);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
